// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one hex-print UART transmit path among N_REQ producers.
// Each producer owns a one-word holding register. A scheduler presents one held word at a
// time downstream over valid/ready. An optional idle gap follows every transfer.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MIN_GAP = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ*DATA_W-1:0]    req_data,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned GAP_W = 8;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;

  typedef enum logic [1:0] {
    StArb,
    StSend,
    StGap
  } state_e;

  state_e                state_q, state_d;
  logic [N_REQ-1:0]      held_q, held_d;
  logic [DATA_W-1:0]     hold_data_q [N_REQ];
  logic [N_REQ-1:0]      load;
  logic [PTR_W-1:0]      rr_q, rr_d;
  logic [PTR_W-1:0]      grant_q, grant_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  xfer;
  logic                  pick_found;
  logic [PTR_W-1:0]      pick_idx;
  logic [PTR_W-1:0]      cand;
  int unsigned           cand_sum;

  // A downstream transfer completes only while presenting a word.
  assign xfer = (state_q == StSend) && out_ready;

  // Capture requests into empty holding registers; the granted slot cannot reload on its
  // completion edge because its held bit is still set in that cycle.
  always_comb begin
    load   = req_valid & ~held_q;
    held_d = held_q;
    if (xfer) begin
      held_d[grant_q] = 1'b0;
    end
    held_d = held_d | load;
  end

  // Holding register flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= '0;
    end else begin
      held_q <= held_d;
    end
  end

  // Holding register payloads, one per requester.
  for (genvar i = 0; i < N_REQ; i++) begin : g_hold
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_data_q[i] <= '0;
      end else if (load[i]) begin
        hold_data_q[i] <= req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin search: first held index starting at rr_q. Scanning offsets high to low
  // lets the smallest offset win. The wrap is explicit so non-power-of-2 N_REQ never
  // produces an out-of-range index.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    cand_sum   = 0;
    for (int off = int'(N_REQ) - 1; off >= 0; off--) begin
      cand_sum = 32'(rr_q) + 32'(off);
      if (cand_sum >= N_REQ) begin
        cand_sum = cand_sum - N_REQ;
      end
      cand = PTR_W'(cand_sum);
      if (held_q[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StArb;
      rr_q    <= '0;
      grant_q <= '0;
      data_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic for the ARB / SEND / GAP sequence.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    data_d  = data_q;
    gap_d   = gap_q;
    unique case (state_q)
      StArb: begin
        if (pick_found) begin
          grant_d = pick_idx;
          data_d  = hold_data_q[pick_idx];
          state_d = StSend;
        end
      end
      StSend: begin
        if (out_ready) begin
          // Pointer moves only on completed transfers, just past the served requester.
          rr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
          if (MIN_GAP > 0) begin
            gap_d   = GAP_LOAD;
            state_d = StGap;
          end else begin
            state_d = StArb;
          end
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StArb;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = StArb;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    out_valid = (state_q == StSend);
    out_data  = data_q;
    grant_id  = grant_q;
    req_ready = ~held_q;
    busy      = (|held_q) || (state_q != StArb);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scoreboard of expected {grant_id, out_data} pairs
// checked at every downstream transfer, plus timing checks on a MIN_GAP = 3 instance.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int PW = 2;

  typedef struct packed {
    logic [PW-1:0] id;
    logic [W-1:0]  data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [PW-1:0]  grant_id;
  logic           busy;

  logic [N*W-1:0] g_req_data;
  logic [N-1:0]   g_req_valid;
  logic [N-1:0]   g_req_ready;
  logic [W-1:0]   g_out_data;
  logic           g_out_valid;
  logic           g_out_ready;
  logic [PW-1:0]  g_grant_id;
  logic           g_busy;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .MIN_GAP(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .MIN_GAP(3)) dut_gap (
    .clk       (clk),
    .rst       (rst),
    .req_data  (g_req_data),
    .req_valid (g_req_valid),
    .req_ready (g_req_ready),
    .out_data  (g_out_data),
    .out_valid (g_out_valid),
    .out_ready (g_out_ready),
    .grant_id  (g_grant_id),
    .busy      (g_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int idx, input logic [W-1:0] word);
    req_data[idx*W +: W] = word;
    req_valid[idx]       = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(n < 200), 64'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Transfers happen at the next rising edge when valid and ready are both high at the
  // falling edge; compare against the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL xfer_unexpected observed %0h:%0h expected none", grant_id, out_data);
      end else begin
        e = sb.pop_front();
        assert ({grant_id, out_data} === e) else begin
          errors++;
          $error("FAIL xfer observed %0h:%0h expected %0h:%0h",
                 grant_id, out_data, e.id, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    req_data    = '0;
    req_valid   = '0;
    out_ready   = 1'b0;
    g_req_data  = '0;
    g_req_valid = '0;
    g_out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state and idle.
    check("rst_out_data", out_data, 64'h0);
    check("rst_grant_id", grant_id, 64'h0);
    for (int i = 0; i < 20; i++) begin
      check("idle", {req_ready, out_valid, busy}, {4'b1111, 1'b0, 1'b0});
      tick();
    end

    // Single word from requester 2.
    out_ready = 1'b1;
    drive(2, 16'hBEEF);
    sb.push_back('{id: 2'd2, data: 16'hBEEF});
    tick();
    req_valid = '0;
    check("single_held_ready", req_ready, 64'b1011);
    check("single_arb_valid", out_valid, 64'd0);
    check("single_busy", busy, 64'd1);
    tick();
    check("single_send", {out_valid, grant_id, out_data}, {1'b1, 2'd2, 16'hBEEF});
    check("single_send_ready", req_ready, 64'b1011);
    tick();
    check("single_done", {out_valid, req_ready}, {1'b0, 4'b1111});
    drain("single_drain");
    check("single_grant_kept", grant_id, 64'd2);

    // Round robin from a fresh pointer; one ARB cycle between back-to-back transfers.
    pulse_reset();
    drive(0, 16'h1111);
    drive(1, 16'h2222);
    drive(2, 16'h3333);
    drive(3, 16'h4444);
    sb.push_back('{id: 2'd0, data: 16'h1111});
    sb.push_back('{id: 2'd1, data: 16'h2222});
    sb.push_back('{id: 2'd2, data: 16'h3333});
    sb.push_back('{id: 2'd3, data: 16'h4444});
    tick();
    req_valid = '0;
    check("rr_all_held", req_ready, 64'b0000);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("rr_cadence_%0d", i), out_valid, 64'(i % 2 == 1));
      tick();
    end
    drain("rr_drain");

    // Pointer now 0 after requester 3: requester 0 goes before requester 3.
    drive(0, 16'h1010);
    drive(3, 16'h4040);
    sb.push_back('{id: 2'd0, data: 16'h1010});
    sb.push_back('{id: 2'd3, data: 16'h4040});
    tick();
    req_valid = '0;
    drain("rr_reload_drain");

    // Backpressure on requester 1.
    out_ready = 1'b0;
    drive(1, 16'hA5A5);
    sb.push_back('{id: 2'd1, data: 16'hA5A5});
    tick();
    req_valid = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("bp_stable", {out_valid, grant_id, out_data, req_ready[1]},
            {1'b1, 2'd1, 16'hA5A5, 1'b0});
      tick();
    end
    // Accept cycle: a new word from the granted requester must be refused.
    out_ready = 1'b1;
    drive(1, 16'h5A5A);
    tick();
    check("bp_released", {out_valid, req_ready[1]}, {1'b0, 1'b1});
    sb.push_back('{id: 2'd1, data: 16'h5A5A});
    tick();
    req_valid = '0;
    check("bp_reload_held", req_ready[1], 64'd0);
    drain("bp_drain");

    // MIN_GAP = 3: three GAP cycles and one ARB cycle between transfers.
    g_req_data[0*W +: W] = 16'hC0C0;
    g_req_data[1*W +: W] = 16'hC1C1;
    g_req_valid          = 4'b0011;
    tick();
    g_req_valid = '0;
    for (int i = 0; i < 11; i++) begin
      check($sformatf("gap_valid_%0d", i), g_out_valid, 64'(i == 1 || i == 6));
      if (i == 1) check("gap_first", {g_grant_id, g_out_data}, {2'd0, 16'hC0C0});
      if (i == 6) check("gap_second", {g_grant_id, g_out_data}, {2'd1, 16'hC1C1});
      if (i == 9) check("gap_busy_in_gap", g_busy, 64'd1);
      if (i == 10) check("gap_busy_idle", g_busy, 64'd0);
      tick();
    end

    // Asynchronous reset in the middle of a SEND.
    out_ready = 1'b0;
    drive(2, 16'hDEAD);
    tick();
    req_valid = '0;
    tick();
    check("ar_sending", out_valid, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_async", {out_valid, busy}, {1'b0, 1'b0});
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("ar_no_stale", {out_valid, busy, req_ready}, {1'b0, 1'b0, 4'b1111});
      tick();
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
